// File: rtl/fpadd_pkg.sv
// Shared types and constants for the sequential single-precision adder.
// Holds the controller state encoding, IEEE-754 field widths and a field-packing helper.
package fpadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX     = 8'd255;
    localparam logic [EXP_W-1:0] ALIGN_LIMIT = 8'd25;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] pack_fp(input logic sgn,
                                            input logic [EXP_W-1:0] expo,
                                            input logic [MAN_W-1:0] man);
        return {sgn, expo, man};
    endfunction

endpackage

// File: rtl/fpadd_unpack.sv
// Splits an IEEE-754 single into fields; denormals flush to a zero magnitude.
// The sign can be flipped so subtraction becomes addition of a negated operand.
module fpadd_unpack
    import fpadd_pkg::*;
(
    input  logic [31:0]      word,
    input  logic             flip,
    output logic             sgn,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W-1:0] man,
    output logic [MAN_W:0]   mag,
    output logic             special
);

    // Field extraction, hidden bit and zero/special detection
    always_comb begin
        sgn     = word[31] ^ flip;
        expo    = word[30:23];
        man     = word[22:0];
        special = (word[30:23] == EXP_MAX);
        if (word[30:23] == 8'd0) begin
            mag = 24'd0;
        end else begin
            mag = {1'b1, word[22:0]};
        end
    end

endmodule

// File: rtl/fpadd_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor with valid/ready handshakes.
// Alignment and normalisation shift one bit per cycle; rounding is truncation.
module fpadd_seq
    import fpadd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf
);

    logic             a_sgn, b_sgn, a_special, b_special;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [MAN_W:0]   a_mag, b_mag;

    fpadd_unpack u_unpack_a (
        .word(a), .flip(1'b0), .sgn(a_sgn), .expo(a_exp),
        .man(a_man), .mag(a_mag), .special(a_special)
    );

    fpadd_unpack u_unpack_b (
        .word(b), .flip(op), .sgn(b_sgn), .expo(b_exp),
        .man(b_man), .mag(b_mag), .special(b_special)
    );

    state_t           state_r, state_s;
    logic             big_sign_r, big_sign_s;
    logic             small_sign_r, small_sign_s;
    logic [MAN_W:0]   big_mag_r, big_mag_s;
    logic [MAN_W:0]   small_mag_r, small_mag_s;
    logic [EXP_W-1:0] exp_r, exp_s;
    logic [4:0]       cnt_r, cnt_s;
    logic             res_sign_r, res_sign_s;
    logic [MAN_W+1:0] mag_r, mag_s;
    logic [31:0]      result_r, result_s;
    logic             ovf_r, ovf_s;

    logic [25:0]      big_tc_s, small_tc_s, sum_s, neg_sum_s;
    logic [EXP_W-1:0] diff_s, exp_inc_s, exp_dec_s;
    logic [MAN_W+1:0] mag_shl_s;

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign result    = result_r;
    assign ovf       = ovf_r;

    // Next-state and datapath update for the controller
    always_comb begin
        state_s      = state_r;
        big_sign_s   = big_sign_r;
        small_sign_s = small_sign_r;
        big_mag_s    = big_mag_r;
        small_mag_s  = small_mag_r;
        exp_s        = exp_r;
        cnt_s        = cnt_r;
        res_sign_s   = res_sign_r;
        mag_s        = mag_r;
        result_s     = result_r;
        ovf_s        = ovf_r;

        if (big_sign_r) begin
            big_tc_s = 26'd0 - {2'b00, big_mag_r};
        end else begin
            big_tc_s = {2'b00, big_mag_r};
        end
        if (small_sign_r) begin
            small_tc_s = 26'd0 - {2'b00, small_mag_r};
        end else begin
            small_tc_s = {2'b00, small_mag_r};
        end
        sum_s     = big_tc_s + small_tc_s;
        neg_sum_s = 26'd0 - sum_s;
        exp_inc_s = exp_r + 8'd1;
        exp_dec_s = exp_r - 8'd1;
        mag_shl_s = {mag_r[MAN_W:0], 1'b0};
        if (b_exp > a_exp) begin
            diff_s = b_exp - a_exp;
        end else begin
            diff_s = a_exp - b_exp;
        end

        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    if (a_special || b_special) begin
                        if (a_special) begin
                            result_s = pack_fp(a_sgn, a_exp, a_man);
                        end else begin
                            result_s = pack_fp(b_sgn, b_exp, b_man);
                        end
                        ovf_s   = 1'b1;
                        state_s = S_DONE;
                    end else begin
                        ovf_s = 1'b0;
                        // Equal exponents keep A as the big operand
                        if (b_exp > a_exp) begin
                            big_sign_s   = b_sgn;
                            big_mag_s    = b_mag;
                            exp_s        = b_exp;
                            small_sign_s = a_sgn;
                            small_mag_s  = a_mag;
                        end else begin
                            big_sign_s   = a_sgn;
                            big_mag_s    = a_mag;
                            exp_s        = a_exp;
                            small_sign_s = b_sgn;
                            small_mag_s  = b_mag;
                        end
                        if (diff_s == 8'd0) begin
                            state_s = S_ADD;
                        end else if (diff_s < ALIGN_LIMIT) begin
                            cnt_s   = diff_s[4:0];
                            state_s = S_ALIGN;
                        end else begin
                            small_mag_s = 24'd0;
                            state_s     = S_ADD;
                        end
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ALIGN: begin
                small_mag_s = small_mag_r >> 1;
                cnt_s       = cnt_r - 5'd1;
                if (cnt_r == 5'd1) begin
                    state_s = S_ADD;
                end else begin
                    state_s = S_ALIGN;
                end
            end
            S_ADD: begin
                res_sign_s = sum_s[25];
                if (sum_s[25]) begin
                    mag_s = neg_sum_s[24:0];
                end else begin
                    mag_s = sum_s[24:0];
                end
                state_s = S_NORM;
            end
            S_NORM: begin
                if (mag_r == 25'd0) begin
                    result_s = 32'h0000_0000;
                    state_s  = S_DONE;
                end else if (mag_r[24]) begin
                    mag_s   = mag_r >> 1;
                    exp_s   = exp_inc_s;
                    state_s = S_DONE;
                    if (exp_inc_s == EXP_MAX) begin
                        result_s = pack_fp(res_sign_r, EXP_MAX, 23'd0);
                        ovf_s    = 1'b1;
                    end else begin
                        result_s = pack_fp(res_sign_r, exp_inc_s, mag_r[23:1]);
                    end
                end else if (mag_r[23]) begin
                    result_s = pack_fp(res_sign_r, exp_r, mag_r[22:0]);
                    state_s  = S_DONE;
                end else begin
                    // One left shift per cycle until the hidden bit lands in bit 23
                    mag_s = mag_shl_s;
                    exp_s = exp_dec_s;
                    if (exp_dec_s == 8'd0) begin
                        result_s = 32'h0000_0000;
                        state_s  = S_DONE;
                    end else if (mag_shl_s[23]) begin
                        result_s = pack_fp(res_sign_r, exp_dec_s, mag_shl_s[22:0]);
                        state_s  = S_DONE;
                    end else begin
                        state_s = S_NORM;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            big_sign_r   <= 1'b0;
            small_sign_r <= 1'b0;
            big_mag_r    <= 24'd0;
            small_mag_r  <= 24'd0;
            exp_r        <= 8'd0;
            cnt_r        <= 5'd0;
            res_sign_r   <= 1'b0;
            mag_r        <= 25'd0;
            result_r     <= 32'd0;
            ovf_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            big_sign_r   <= big_sign_s;
            small_sign_r <= small_sign_s;
            big_mag_r    <= big_mag_s;
            small_mag_r  <= small_mag_s;
            exp_r        <= exp_s;
            cnt_r        <= cnt_s;
            res_sign_r   <= res_sign_s;
            mag_r        <= mag_s;
            result_r     <= result_s;
            ovf_r        <= ovf_s;
        end
    end

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed self-checking bench for fpadd_seq: hand-computed results and latencies,
// backpressure, handshake-cycle acceptance and asynchronous reset mid-operation.
module tb_fpadd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int lat;

    fpadd_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present one operand pair; lat = rising edges from accept edge to out_valid
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top);
        @(negedge clk);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                            input logic top, input logic [31:0] expr, input logic expo,
                            input int explat);
        run_op(ta, tb, top);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, result, expr);
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expo});
        check({tag, "_lat"}, lat, explat);
        drain();
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;

        op_check("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 3);
        op_check("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 4);
        op_check("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 3);
        op_check("far_small", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 3);
        op_check("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 3);
        op_check("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1);
        op_check("one_minus_p75", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 5);
        op_check("two_plus_neg3", 32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 1'b0, 3);
        op_check("one_p5_minus_one", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 3);

        // Backpressure: result held, new operands ignored while DONE
        run_op(32'h3F800000, 32'h3F800000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 32'h40400000; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_result", result, 32'h40000000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("hs_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("hs_no_accept", {31'd0, in_ready}, 32'd1);
        end

        // Reset during ALIGN of a d = 10 operation
        @(negedge clk);
        a = 32'h44800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_result", {31'd0, out_valid}, 32'd0);
        end

        op_check("k1024_plus_one", 32'h44800000, 32'h3F800000, 1'b0, 32'h44802000, 1'b0, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
